// File: rtl/riscv32_pkg.sv
// riscv32_pkg: shared register-file constants and the writeback entry type
package riscv32_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: writeback request, register-file write port and hazard signals
interface regfile_writeback_if import riscv32_pkg::*; #(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 2
);
    logic                         alu_valid;
    logic                         alu_ready;
    logic [REG_ADDR_W-1:0]        alu_rd;
    logic [WIDTH-1:0]             alu_data;
    logic                         mem_valid;
    logic                         mem_ready;
    logic [REG_ADDR_W-1:0]        mem_rd;
    logic [WIDTH-1:0]             mem_data;
    logic                         rf_hold;
    logic                         rf_write_enabled;
    logic [REG_ADDR_W-1:0]        rf_write_location;
    logic [WIDTH-1:0]             rf_write_data;
    logic [REG_ADDR_W-1:0]        read1_location;
    logic [REG_ADDR_W-1:0]        read2_location;
    logic                         read1_pending;
    logic                         read2_pending;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rf_hold,
               read1_location, read2_location,
        input  alu_ready, mem_ready, rf_write_enabled, rf_write_location, rf_write_data,
               read1_pending, read2_pending, occupancy
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rf_hold,
               read1_location, read2_location,
        output alu_ready, mem_ready, rf_write_enabled, rf_write_location, rf_write_data,
               read1_pending, read2_pending, occupancy
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: in-order circular queue of {rd, data} with per-entry valid/rd exposed for hazard compare
module wb_fifo import riscv32_pkg::*; #(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic [REG_ADDR_W-1:0]                push_rd,
    input  logic [WIDTH-1:0]                     push_data,
    output logic                                 full,
    output logic                                 empty,
    output logic [$clog2(DEPTH+1)-1:0]           occupancy,
    output logic [REG_ADDR_W-1:0]                head_rd,
    output logic [WIDTH-1:0]                     head_data,
    output logic [DEPTH-1:0]                     entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_rd
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = occupancy == CW'(DEPTH);
    assign empty     = occupancy == '0;
    assign head_rd   = entry_rd[head];
    assign head_data = data_q[head];

    // Pop clears the head slot before push fills the tail, so a full-queue push+pop on the same slot keeps it valid
    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            occupancy   <= '0;
            entry_valid <= '0;
            entry_rd    <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
            if (pop) begin
                head              <= wrap_inc(head);
                entry_valid[head] <= 1'b0;
            end
            if (push) begin
                tail              <= wrap_inc(tail);
                entry_valid[tail] <= 1'b1;
                entry_rd[tail]    <= push_rd;
                data_q[tail]      <= push_data;
            end
            occupancy <= occupancy + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates ALU/load writebacks into a queue feeding the register-file write port
module regfile_writeback import riscv32_pkg::*; #(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 2
) (
    input logic                 clk,
    input logic                 reset,
    regfile_writeback_if.slave  bus
);
    logic                             full;
    logic                             empty;
    logic                             push;
    logic                             pop;
    logic [REG_ADDR_W-1:0]            push_rd;
    logic [WIDTH-1:0]                 push_data;
    logic [REG_ADDR_W-1:0]            head_rd;
    logic [WIDTH-1:0]                 head_data;
    logic [DEPTH-1:0]                 entry_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;
    logic                             p1;
    logic                             p2;

    // A full queue still accepts when the head drains on the same edge
    assign bus.mem_ready = !full || !bus.rf_hold;
    assign bus.alu_ready = bus.mem_ready && !bus.mem_valid;

    // Loads win; writes to x0 complete the handshake but never enter the queue
    assign push_rd   = bus.mem_valid ? bus.mem_rd : bus.alu_rd;
    assign push_data = bus.mem_valid ? bus.mem_data : bus.alu_data;
    assign push      = (bus.mem_valid || bus.alu_valid) && bus.mem_ready && push_rd != '0;
    assign pop       = !empty && !bus.rf_hold;

    assign bus.rf_write_enabled  = pop;
    assign bus.rf_write_location = empty ? '0 : head_rd;
    assign bus.rf_write_data     = empty ? '0 : head_data;

    wb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .push_rd     (push_rd),
        .push_data   (push_data),
        .full        (full),
        .empty       (empty),
        .occupancy   (bus.occupancy),
        .head_rd     (head_rd),
        .head_data   (head_data),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

    // Flag decode reads whose register still has a queued write; x0 never hazards
    always_comb begin
        p1 = 1'b0;
        p2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            p1 = p1 | (entry_valid[i] && entry_rd[i] == bus.read1_location);
            p2 = p2 | (entry_valid[i] && entry_rd[i] == bus.read2_location);
        end
    end

    assign bus.read1_pending = p1 && bus.read1_location != '0;
    assign bus.read2_pending = p2 && bus.read2_location != '0;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed vector table, reset sequences and random traffic against a queue model
module tb_regfile_writeback;
    localparam int DEPTH = 2;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_writeback_if #(.WIDTH(W), .DEPTH(DEPTH)) bus();
    regfile_writeback #(.WIDTH(W), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
    ent_t q[$];

    typedef struct {
        int av; int ard; logic [31:0] ad;
        int mv; int mrd; logic [31:0] md;
        int hold; int r1; int r2;
        int we; int loc; logic [31:0] wd;
        int occ; int ar; int mr; int p1; int p2;
    } vec_t;
    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input int av, input int ard, input logic [31:0] ad, input int mv, input int mrd,
                          input logic [31:0] md, input int hold, input int r1, input int r2);
        bus.alu_valid = av[0];
        bus.alu_rd = ard[4:0];
        bus.alu_data = ad;
        bus.mem_valid = mv[0];
        bus.mem_rd = mrd[4:0];
        bus.mem_data = md;
        bus.rf_hold = hold[0];
        bus.read1_location = r1[4:0];
        bus.read2_location = r2[4:0];
    endtask

    task automatic model_check(input string tag);
        int n;
        logic mr, p1, p2;
        ent_t head;
        n = q.size();
        head = '0;
        if (n > 0) head = q[0];
        mr = n < DEPTH || !bus.rf_hold;
        p1 = 1'b0;
        p2 = 1'b0;
        foreach (q[i]) begin
            if (q[i].rd == bus.read1_location && bus.read1_location != 0) p1 = 1'b1;
            if (q[i].rd == bus.read2_location && bus.read2_location != 0) p2 = 1'b1;
        end
        chk({tag, ".occ"}, 32'(bus.occupancy), 32'(n));
        chk({tag, ".we"}, 32'(bus.rf_write_enabled), 32'(n > 0 && !bus.rf_hold));
        chk({tag, ".loc"}, 32'(bus.rf_write_location), 32'(head.rd));
        chk({tag, ".wdata"}, bus.rf_write_data, head.data);
        chk({tag, ".mem_ready"}, 32'(bus.mem_ready), 32'(mr));
        chk({tag, ".alu_ready"}, 32'(bus.alu_ready), 32'(mr && !bus.mem_valid));
        chk({tag, ".p1"}, 32'(bus.read1_pending), 32'(p1));
        chk({tag, ".p2"}, 32'(bus.read2_pending), 32'(p2));
    endtask

    task automatic model_update();
        logic mr;
        if (reset) begin
            q.delete();
        end else begin
            mr = q.size() < DEPTH || !bus.rf_hold;
            if (q.size() > 0 && !bus.rf_hold) void'(q.pop_front());
            if (bus.mem_valid && mr) begin
                if (bus.mem_rd != 0) q.push_back({bus.mem_rd, bus.mem_data});
            end else if (bus.alu_valid && mr) begin
                if (bus.alu_rd != 0) q.push_back({bus.alu_rd, bus.alu_data});
            end
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        model_check(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        vecs = '{
            '{0,0,0,            0,0,0,       0,0,0, 0,0,0,            0,1,1,0,0},
            '{1,5,32'hDEADBEEF, 0,0,0,       0,0,0, 0,0,0,            0,1,1,0,0},
            '{0,0,0,            0,0,0,       0,5,0, 1,5,32'hDEADBEEF, 1,1,1,1,0},
            '{0,0,0,            0,0,0,       0,5,0, 0,0,0,            0,1,1,0,0},
            '{1,4,'h22,         1,3,'h11,    0,0,0, 0,0,0,            0,0,1,0,0},
            '{1,4,'h22,         0,0,0,       0,0,0, 1,3,'h11,         1,1,1,0,0},
            '{0,0,0,            0,0,0,       0,0,0, 1,4,'h22,         1,1,1,0,0},
            '{0,0,0,            0,0,0,       0,0,0, 0,0,0,            0,1,1,0,0},
            '{1,7,'h70,         0,0,0,       1,0,0, 0,0,0,            0,1,1,0,0},
            '{1,8,'h80,         0,0,0,       1,8,7, 0,7,'h70,         1,1,1,0,1},
            '{0,0,0,            0,0,0,       1,8,7, 0,7,'h70,         2,0,0,1,1},
            '{0,0,0,            0,0,0,       0,8,7, 1,7,'h70,         2,1,1,1,1},
            '{0,0,0,            0,0,0,       0,8,7, 1,8,'h80,         1,1,1,1,0},
            '{0,0,0,            0,0,0,       0,8,7, 0,0,0,            0,1,1,0,0},
            '{1,9,'h90,         0,0,0,       1,0,0, 0,0,0,            0,1,1,0,0},
            '{1,10,'hA0,        0,0,0,       1,0,0, 0,9,'h90,         1,1,1,0,0},
            '{1,12,'hC0,        1,11,'hB0,   0,0,0, 1,9,'h90,         2,0,1,0,0},
            '{0,0,0,            0,0,0,       0,0,0, 1,10,'hA0,        2,1,1,0,0},
            '{0,0,0,            0,0,0,       0,0,0, 1,11,'hB0,        1,1,1,0,0},
            '{0,0,0,            0,0,0,       0,0,0, 0,0,0,            0,1,1,0,0},
            '{1,0,32'hFFFFFFFF, 0,0,0,       0,0,0, 0,0,0,            0,1,1,0,0},
            '{0,0,0,            1,0,'h1234,  0,0,0, 0,0,0,            0,0,1,0,0},
            '{0,0,0,            0,0,0,       0,0,0, 0,0,0,            0,1,1,0,0}
        };
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        q.delete();

        foreach (vecs[i]) begin
            string t;
            vec_t v;
            v = vecs[i];
            t = $sformatf("vec%0d", i);
            set_in(v.av, v.ard, v.ad, v.mv, v.mrd, v.md, v.hold, v.r1, v.r2);
            @(negedge clk);
            chk({t, ".we"}, 32'(bus.rf_write_enabled), 32'(v.we));
            chk({t, ".loc"}, 32'(bus.rf_write_location), 32'(v.loc));
            chk({t, ".wdata"}, bus.rf_write_data, v.wd);
            chk({t, ".occ"}, 32'(bus.occupancy), 32'(v.occ));
            chk({t, ".alu_ready"}, 32'(bus.alu_ready), 32'(v.ar));
            chk({t, ".mem_ready"}, 32'(bus.mem_ready), 32'(v.mr));
            chk({t, ".p1"}, 32'(bus.read1_pending), 32'(v.p1));
            chk({t, ".p2"}, 32'(bus.read2_pending), 32'(v.p2));
            model_check({t, ".model"});
            @(posedge clk);
            model_update();
            #1;
        end

        set_in(1, 12, 'hC, 0, 0, 0, 1, 0, 0);
        step("rst_fill0");
        set_in(1, 13, 'hD, 0, 0, 0, 1, 12, 13);
        step("rst_fill1");
        set_in(0, 0, 0, 1, 14, 'hE, 1, 12, 13);
        @(negedge clk);
        chk("rst_full.occ", 32'(bus.occupancy), 32'd2);
        chk("rst_full.p1", 32'(bus.read1_pending), 32'd1);
        chk("rst_full.p2", 32'(bus.read2_pending), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        model_update();
        #1 reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 12, 13);
        @(negedge clk);
        chk("rst_after.occ", 32'(bus.occupancy), 32'd0);
        chk("rst_after.we", 32'(bus.rf_write_enabled), 32'd0);
        chk("rst_after.loc", 32'(bus.rf_write_location), 32'd0);
        chk("rst_after.wdata", bus.rf_write_data, 32'd0);
        chk("rst_after.p1", 32'(bus.read1_pending), 32'd0);
        chk("rst_after.p2", 32'(bus.read2_pending), 32'd0);
        chk("rst_after.alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("rst_after.mem_ready", 32'(bus.mem_ready), 32'd1);
        repeat (3) step("rst_idle");

        set_in(1, 20, 'h20, 0, 0, 0, 1, 0, 0);
        step("rst_push0");
        set_in(1, 21, 'h21, 0, 0, 0, 1, 21, 20);
        reset = 1'b1;
        step("rst_push1");
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 21, 20);
        @(negedge clk);
        chk("rst_push.occ", 32'(bus.occupancy), 32'd0);
        chk("rst_push.p1", 32'(bus.read1_pending), 32'd0);
        repeat (2) step("rst_push_idle");

        for (int c = 0; c < 3000; c++) begin
            set_in(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                   int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)), $urandom,
                   int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            reset = $urandom_range(0, 149) == 0;
            step($sformatf("rnd%0d", c));
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side initiator for the riscv32 register file: accepts register-writeback requests from the ALU and load paths via valid/ready handshakes, buffers them in a small in-order queue, and drives the register file's single write port one entry per cycle. It also flags read-after-write hazards for the two decode-stage read locations while matching writes are still queued.

## Interface
- WIDTH, 32, data width of a register
- DEPTH, 2, pending-write queue entries (≥2, any integer)
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle when high with alu_valid
- alu_rd  in  5  ALU destination register
- alu_data  in  WIDTH  ALU result
- mem_valid  in  1  load writeback request
- mem_ready  out  1  load request accepted this cycle when high with mem_valid
- mem_rd  in  5  load destination register
- mem_data  in  WIDTH  load result
- rf_hold  in  1  write port unavailable this cycle; no drain
- rf_write_enabled  out  1  to register file write_enabled
- rf_write_location  out  5  to register file write_location
- rf_write_data  out  WIDTH  to register file write_data
- read1_location  in  5  decode-stage read port 1 address
- read2_location  in  5  decode-stage read port 2 address
- read1_pending  out  1  queued write targets read1_location
- read2_pending  out  1  queued write targets read2_location
- occupancy  out  $clog2(DEPTH+1)  current queue entries

## Operation
- Queue: circular FIFO, DEPTH entries of {rd, data}; head/tail pointers wrap from DEPTH-1 to 0; occupancy counter 0..DEPTH.
- Pop: when occupancy>0 and !rf_hold, head entry is driven to the write port and removed at the clock edge.
- Push: at most one request per cycle. Priority mem over alu.
- mem_ready = (occupancy<DEPTH) || !rf_hold (comb.).
- alu_ready = mem_ready && !mem_valid.
- Simultaneous push and pop with queue full: legal (pop frees slot same edge); occupancy unchanged.
- rd==0 requests: handshake completes normally (ready as above), entry is discarded, never enqueued, occupancy unchanged.
- rf_write_enabled = (occupancy>0) && !rf_hold; rf_write_location/rf_write_data = head entry whenever occupancy>0, else 0. Driven purely from registered state plus rf_hold.
- readN_pending = readN_location≠0 and matches rd of any occupied entry. Accepted-but-not-yet-queued requests do not count.
- Strict in-order writes: two queued writes to same rd both reach the register file, later one last.
- Reset: occupancy, pointers, all entries cleared; queued writes discarded (never reach register file). Reset overrides push and pop in the same cycle.

## Timing
- Reset values: rf_write_enabled 0, rf_write_location 0, rf_write_data 0, read1_pending 0, read2_pending 0, occupancy 0; alu_ready/mem_ready 1 (comb. from empty queue).
- Request accepted at edge N → rf_write_enabled high during cycle N..N+1 (if !rf_hold) → register file updated at edge N+1. Minimum latency accept-to-architectural-state: 1 cycle.
- Pending flag set the cycle after acceptance, clears the cycle after the entry pops.
- Throughput: one write per cycle sustained with rf_hold low.
- ready signals combinational from state and rf_hold/mem_valid only; no dependence on alu_valid.

## Structure
- Package riscv32_pkg: REG_ADDR_W=5, typedef wb_entry_t {logic [4:0] rd; logic [WIDTH-1:0] data} (WIDTH via package constant XLEN=32).
- Sub-module wb_fifo: generic DEPTH-entry FIFO with push/pop/full/empty/occupancy and exposed entry-valid/rd vector for hazard compare. Top level holds arbitration, x0 filter, hazard match.

## Test plan
- Reset then single ALU write rd=5 data=0xDEADBEEF, rf_hold=0 → next cycle rf_write_enabled=1, location=5, data=0xDEADBEEF; occupancy 1 then 0.
- mem_valid and alu_valid same cycle (mem rd=3 0x11, alu rd=4 0x22) → mem accepted, alu_ready=0; alu accepted next cycle; writes to 3 then 4 on consecutive cycles.
- rf_hold=1, push rd=7, rd=8 → occupancy 2, both ready low; read1_location=8 → read1_pending=1; release hold → writes 7, 8 in order, pending clears.
- Full queue with rf_hold=0 and mem_valid → mem_ready=1, push+pop same edge, occupancy stays 2.
- alu rd=0 data=0xFFFFFFFF → alu_ready=1, occupancy stays 0, rf_write_enabled never asserts; read1_location=0 → read1_pending=0.
- Queue holding 2 entries, assert reset 1 cycle → no rf write for those entries, occupancy 0, all outputs at reset values.
